// File: rtl/idct_pkg.sv
// Shared IDCT types and constants used by the row pass, transpose buffer and column pass.
package idct_pkg;

   localparam int INT16_W = 16;
   localparam int IDCT_N  = 8;

   typedef logic signed [INT16_W-1:0] int16_t;
   typedef int16_t [IDCT_N-1:0]       row_t;

   // Fixed-point cosine weights (2048*sqrt(2)*cos(k*pi/16)) for the butterfly stages.
   localparam int W1 = 2841;
   localparam int W2 = 2676;
   localparam int W3 = 2408;
   localparam int W5 = 1609;
   localparam int W6 = 1108;
   localparam int W7 = 565;

   // Rounding and scaling constants shared by the row and column passes.
   localparam int C128  = 128;
   localparam int C181  = 181;
   localparam int C4    = 4;
   localparam int C8192 = 8192;

endpackage

// File: rtl/idct_tbuf_bank.sv
// One N x N sample bank: row-wide write port, column-wide combinational read port.
module idct_tbuf_bank
   import idct_pkg::*;
#(
   parameter int WIDTH = INT16_W,
   parameter int N     = IDCT_N,
   localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clock,
   input  logic               we,
   input  logic [IW-1:0]      wrow,
   input  logic [N*WIDTH-1:0] wdata,
   input  logic [IW-1:0]      rcol,
   output logic [N*WIDTH-1:0] rdata
);

   // mem[row][col]; a row write drops in_data straight in since element c sits at c*WIDTH
   logic [N-1:0][N-1:0][WIDTH-1:0] mem;

   // Sample storage is deliberately unreset: the top gates the output while a bank is empty.
   always_ff @(posedge clock) begin
      if (we) mem[wrow] <= wdata;
   end

   for (genvar r = 0; r < N; r++) begin : g_col
      assign rdata[r*WIDTH +: WIDTH] = mem[r][rcol];
   end

endmodule

// File: rtl/idct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in from the row-pass IDCT, columns out to the column pass.
module idct_transpose_buf
   import idct_pkg::*;
#(
   parameter int WIDTH = INT16_W,
   parameter int N     = IDCT_N
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic               out_last
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   logic [1:0]                  full;
   logic                        wsel, rsel;
   logic [IW-1:0]               wrow, rcol;
   logic                        wfire, rfire, wlast, rlast;
   logic [1:0]                  full_set, full_clr;
   logic [1:0][N*WIDTH-1:0]     bank_rdata;

   assign in_ready  = !full[wsel];
   assign out_valid = full[rsel];
   assign wfire     = in_valid && in_ready;
   assign rfire     = out_valid && out_ready;
   assign wlast     = (wrow == LAST);
   assign rlast     = (rcol == LAST);

   // Flag updates for both banks; a bank filling and the other draining can coincide.
   always_comb begin
      full_set = '0;
      full_clr = '0;
      if (wfire && wlast) full_set[wsel] = 1'b1;
      if (rfire && rlast) full_clr[rsel] = 1'b1;
   end

   // Write/read pointers and full flags; counters wrap explicitly at N-1.
   always_ff @(posedge clock) begin
      if (reset) begin
         full <= '0;
         wsel <= 1'b0;
         rsel <= 1'b0;
         wrow <= '0;
         rcol <= '0;
      end else begin
         full <= (full | full_set) & ~full_clr;
         if (wfire) begin
            if (wlast) begin
               wrow <= '0;
               wsel <= ~wsel;
            end else begin
               wrow <= wrow + 1'b1;
            end
         end
         if (rfire) begin
            if (rlast) begin
               rcol <= '0;
               rsel <= ~rsel;
            end else begin
               rcol <= rcol + 1'b1;
            end
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      idct_tbuf_bank #(.WIDTH(WIDTH), .N(N)) u_bank (
         .clock (clock),
         .we    (wfire && (wsel == 1'(b))),
         .wrow  (wrow),
         .wdata (in_data),
         .rcol  (rcol),
         .rdata (bank_rdata[b])
      );
   end

   // Column mux with zero gating so stale samples never leak out of an empty bank.
   always_comb begin
      out_data = '0;
      if (out_valid) out_data = bank_rdata[rsel];
   end

   assign out_last = out_valid && rlast;

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Self-checking bench for idct_transpose_buf: scoreboard of expected columns plus directed sequences.
module tb_idct_transpose_buf;

   typedef logic [7:0][7:0][15:0] blk_t;   // [row][col]
   typedef struct { logic [127:0] d; logic l; } exp_t;
   typedef struct { int col; int row; logic [15:0] exp; } vec_t;

   logic         clock = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_last;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   bit   mon_en  = 1'b0;
   bit   rdy_mode = 1'b0;
   logic [127:0] cap_d [8];
   logic         cap_l [8];

   idct_transpose_buf dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] col_of(input blk_t b, input int c);
      logic [7:0][15:0] v;
      for (int r = 0; r < 8; r++) v[r] = b[r][c];
      return v;
   endfunction

   function automatic blk_t rand_blk();
      blk_t b;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) b[r][c] = 16'($urandom);
      return b;
   endfunction

   task automatic push_block(input blk_t b);
      exp_t e;
      for (int c = 0; c < 8; c++) begin
         e.d = col_of(b, c);
         e.l = (c == 7);
         q.push_back(e);
      end
   endtask

   // Present one row from a negedge, wait for in_ready, return just after the firing edge.
   task automatic send_row(input logic [127:0] d, output int waits);
      waits = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready) begin
         waits++;
         if (waits > 2000) begin
            $display("FAIL send_row: in_ready stuck low, got 0 want 1");
            $fatal(1, "write side hung");
         end
         @(negedge clock);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic send_block(input blk_t b, output int waits);
      int w;
      waits = 0;
      for (int r = 0; r < 8; r++) begin
         send_row(b[r], w);
         waits += w;
         if (r == 7) push_block(b);
      end
   endtask

   task automatic set_rdy(input logic v);
      @(posedge clock);
      #1;
      out_ready = v;
   endtask

   task automatic capture();
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         cap_d[c] = out_data;
         cap_l[c] = out_last;
      end
   endtask

   task automatic wait_drain(input string nm);
      int t = 0;
      while (q.size() != 0 && t < 2000) begin
         @(negedge clock);
         t++;
      end
      @(negedge clock);
      chk(nm, q.size(), 0);
   endtask

   // Randomised backpressure when enabled; otherwise main owns out_ready.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rdy_mode) out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Output monitor: scoreboard pops, hold stability under stall, zero gating when idle.
   initial begin
      logic         pv, pr, pl;
      logic [127:0] pd;
      exp_t         e;
      pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            if (!out_valid) chk("idle_gate", {out_last, out_data}, '0);
            if (pv && !pr) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_data", out_data, pd);
               chk("hold_last", out_last, pl);
            end
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_col: got %h want none", out_data);
               end else begin
                  e = q.pop_front();
                  chk("col_data", out_data, e.d);
                  chk("col_last", out_last, e.l);
               end
            end
            pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
         end else begin
            pv = 1'b0;
         end
      end
   end

   initial begin
      vec_t tv1 [6];
      vec_t tv2 [5];
      blk_t b, b2;
      int   w;

      tv1[0] = '{0, 0, 16'd0};   tv1[1] = '{0, 1, 16'd16};
      tv1[2] = '{0, 7, 16'd112}; tv1[3] = '{7, 0, 16'd7};
      tv1[4] = '{7, 3, 16'd55};  tv1[5] = '{7, 7, 16'd119};
      tv2[0] = '{0, 0, 16'h8000}; tv2[1] = '{1, 0, 16'hFF80};
      tv2[2] = '{2, 0, 16'h7FFF}; tv2[3] = '{3, 0, 16'h0001};
      tv2[4] = '{4, 0, 16'h0000};

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      mon_en = 1'b1;

      // Block of 16*r+c with downstream stalled, then drained
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) b[r][c] = 16'(16 * r + c);
      for (int r = 0; r < 7; r++) begin
         send_row(b[r], w);
         chk("t1_row_wait", w, 0);
      end
      @(negedge clock);
      chk("t1_valid_before", out_valid, 0);
      send_row(b[7], w);
      chk("t1_row7_wait", w, 0);
      push_block(b);
      @(negedge clock);
      chk("t1_valid_after", out_valid, 1);
      chk("t1_last_c0", out_last, 0);
      set_rdy(1'b1);
      capture();
      for (int i = 0; i < 6; i++)
         chk($sformatf("t1_c%0d_r%0d", tv1[i].col, tv1[i].row),
             cap_d[tv1[i].col][tv1[i].row*16 +: 16], tv1[i].exp);
      chk("t1_last_c7", cap_l[7], 1);
      chk("t1_last_c6", cap_l[6], 0);
      wait_drain("t1_drain");

      // Three blocks back-to-back with downstream always ready
      w = 0;
      for (int k = 0; k < 3; k++) begin
         int wk;
         send_block(rand_blk(), wk);
         w += wk;
      end
      chk("t2_no_stall", w, 0);
      wait_drain("t2_drain");

      // Both banks full: in_ready drops, returns the cycle after the 8th column fire
      set_rdy(1'b0);
      send_block(rand_blk(), w);
      chk("t3_blkA_wait", w, 0);
      send_block(rand_blk(), w);
      chk("t3_blkB_wait", w, 0);
      @(negedge clock);
      chk("t3_full_ready", in_ready, 0);
      set_rdy(1'b1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk($sformatf("t3_ready_low%0d", i), in_ready, 0);
      end
      @(posedge clock);
      #1 out_ready = 1'b0;
      @(negedge clock);
      chk("t3_ready_back", in_ready, 1);
      set_rdy(1'b1);
      wait_drain("t3_drain");

      // Column 3 held for 4 stalled cycles, then random stalls over two more blocks
      set_rdy(1'b0);
      b = rand_blk();
      send_block(b, w);
      set_rdy(1'b1);
      repeat (3) @(posedge clock);
      #1 out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("t4_hold_c3", {out_valid, out_last, out_data}, {1'b1, 1'b0, col_of(b, 3)});
      end
      rdy_mode = 1'b1;
      send_block(rand_blk(), w);
      send_block(rand_blk(), w);
      wait_drain("t4_drain");
      rdy_mode = 1'b0;

      // Extreme signed values pass through untouched
      set_rdy(1'b1);
      b = rand_blk();
      b[0] = '0;
      b[0][0] = 16'h8000; b[0][1] = 16'hFF80; b[0][2] = 16'h7FFF; b[0][3] = 16'h0001;
      send_block(b, w);
      capture();
      for (int i = 0; i < 5; i++)
         chk($sformatf("t5_c%0d_r%0d", tv2[i].col, tv2[i].row),
             cap_d[tv2[i].col][tv2[i].row*16 +: 16], tv2[i].exp);
      wait_drain("t5_drain");

      // Reset with one full bank and a 5-row partial bank
      set_rdy(1'b0);
      send_block(rand_blk(), w);
      b2 = rand_blk();
      for (int r = 0; r < 5; r++) send_row(b2[r], w);
      mon_en = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      q.delete();
      @(negedge clock);
      chk("t6_out_valid", out_valid, 0);
      chk("t6_out_data", out_data, 0);
      chk("t6_in_ready", in_ready, 1);
      mon_en = 1'b1;
      set_rdy(1'b1);
      send_block(rand_blk(), w);
      chk("t6_fresh_wait", w, 0);
      wait_drain("t6_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
